// File: rtl/fpa.sv
// fpa: single-precision (binary32) floating-point adder with a registered result.
// The sum is normalized and truncated (round toward zero). Subnormal inputs are
// flushed to zero. The result appears one clock after the operands are applied.
// Optional feature macro: FPA_SPECIAL_EN. When it is defined, exponent-255
// inputs are decoded as IEEE-754 infinities and NaNs. When it is undefined,
// exponent 255 is treated as an ordinary finite exponent.
module fpa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow
);

    // Unpacked operand fields.
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb;

    assign sa = a[31];
    assign ea = a[30:23];
    assign fa = a[22:0];
    assign sb = b[31];
    assign eb = b[30:23];
    assign fb = b[22:0];
    assign za = (ea == 8'd0);   // zero or subnormal, which is flushed to zero
    assign zb = (eb == 8'd0);

    // Magnitude ordering and alignment.
    logic        a_big;
    logic        s_big;
    logic        eff_sub;
    logic [7:0]  e_big, e_small, e_diff;
    logic [23:0] m_big, m_small, m_align;
    logic [24:0] add_raw;
    logic [23:0] sub_raw;
    logic [4:0]  lzc;

    assign a_big   = ({ea, fa} >= {eb, fb});
    assign s_big   = a_big ? sa : sb;
    assign e_big   = a_big ? ea : eb;
    assign e_small = a_big ? eb : ea;
    assign m_big   = a_big ? {1'b1, fa} : {1'b1, fb};
    assign m_small = a_big ? {1'b1, fb} : {1'b1, fa};
    assign e_diff  = e_big - e_small;
    assign eff_sub = sa ^ sb;

    // Bits shifted out of the small significand are dropped. A shift of 24 or
    // more leaves nothing.
    assign m_align = (e_diff >= 8'd24) ? 24'd0 : (m_small >> e_diff);
    assign add_raw = {1'b0, m_big} + {1'b0, m_align};
    assign sub_raw = m_big - m_align;   // never negative because big >= small

    // Leading-zero count of the difference. The highest set bit wins because
    // it is assigned last.
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sub_raw[i]) lzc = 5'(23 - i);
        end
    end

    // Normalized fraction and exponent. The exponent is signed and 10 bits
    // wide so that underflow and overflow can both be detected.
    logic [22:0] frac_n;
    logic [9:0]  exp_n;

    // Normalize the sum or the difference.
    always_comb begin
        frac_n = add_raw[22:0];
        exp_n  = {2'b00, e_big};
        if (eff_sub) begin
            frac_n = 23'(sub_raw << lzc);
            exp_n  = {2'b00, e_big} - {5'b00000, lzc};
        end else if (add_raw[24]) begin
            frac_n = add_raw[23:1];
            exp_n  = {2'b00, e_big} + 10'd1;
        end
    end

`ifdef FPA_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf = (eb == 8'hFF) && (fb == 23'd0);
`endif

    logic [31:0] sum_d, sum_q;
    logic        ovf_d, ovf_q;

    // Select the result, handling zero operands, cancellation, underflow and overflow.
    always_comb begin
        sum_d = 32'd0;
        ovf_d = 1'b0;
        if (za && zb) begin
            sum_d = {sa & sb, 31'd0};          // only -0 + -0 stays negative
        end else if (za) begin
            sum_d = b;
        end else if (zb) begin
            sum_d = a;
        end else if (eff_sub && (sub_raw == 24'd0)) begin
            sum_d = 32'd0;                      // exact cancellation gives +0
        end else if (exp_n[9] || (exp_n == 10'd0)) begin
            sum_d = {s_big, 31'd0};             // underflow gives a signed zero
        end else if (exp_n >= 10'd255) begin
            sum_d = {s_big, 8'hFF, 23'd0};      // saturate to infinity
            ovf_d = 1'b1;
        end else begin
            sum_d = {s_big, exp_n[7:0], frac_n};
        end
`ifdef FPA_SPECIAL_EN
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum_d = 32'h7FC0_0000;
            ovf_d = 1'b0;
        end else if (a_inf) begin
            sum_d = a;
            ovf_d = 1'b0;
        end else if (b_inf) begin
            sum_d = b;
            ovf_d = 1'b0;
        end
`endif
    end

    // Output register. Reset clears it immediately and discards any result in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'd0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fpa.sv
// Directed testbench for fpa. Every expected value is hand-computed from the
// truncating add/subtract algorithm.
module tb_fpa;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;

    fpa dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .sum      (sum),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_total++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp_v);
        end
    endtask

    // Apply operands on a falling edge, then check the result just after the next rising edge.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] es, input logic eo);
        @(negedge clk);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        $display("vec %-10s a=%08h b=%08h sum=%08h ovf=%0b", tag, va, vb, sum, overflow);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        rst_n = 1'b1;
        a     = 32'd0;
        b     = 32'd0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst.sum", sum, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        a = 32'h7F7F_FFFF;
        b = 32'h7F7F_FFFF;
        @(posedge clk);
        #1;
        chk("rst_hold.sum", sum, 32'd0);
        chk("rst_hold.ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back operands, one per cycle.
        run_vec("add1",    32'h4201_9999, 32'h4124_CCCC, 32'h422A_CCCC, 1'b0);
        run_vec("align3",  32'h4304_3FBE, 32'h419F_5C28, 32'h4318_2B43, 1'b0);
        run_vec("sub_pos", 32'hC207_C28F, 32'h4243_B852, 32'h416F_D70C, 1'b0);
        run_vec("sub_neg", 32'h4207_C28F, 32'hC243_B852, 32'hC16F_D70C, 1'b0);
        run_vec("neg_add", 32'hC175_C28F, 32'hC1C4_CCCC, 32'hC21F_D709, 1'b0);
        run_vec("trunc",   32'hBF9D_70A3, 32'hC1B4_28F5, 32'hC1BD_FFFF, 1'b0);
        run_vec("ovf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        run_vec("cancel",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0);
        run_vec("zero_a",  32'h0000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0);
        run_vec("zero_b",  32'hC040_0000, 32'h8000_0000, 32'hC040_0000, 1'b0);
        run_vec("nz_nz",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_vec("nz_pz",   32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_vec("subn",    32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        run_vec("undfl",   32'h0080_0000, 32'h80C0_0000, 32'h8000_0000, 1'b0);
        run_vec("shift24", 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0);
        run_vec("shift23", 32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 1'b0);
`ifdef FPA_SPECIAL_EN
        run_vec("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
        run_vec("inf_fin", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0);
`else
        run_vec("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 1'b0);
        run_vec("e255_fin", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1);
`endif

        // The output is registered: new operands must not show before the edge.
        run_vec("lat_a",   32'h4201_9999, 32'h4124_CCCC, 32'h422A_CCCC, 1'b0);
        @(negedge clk);
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        #1;
        chk("lat_hold", sum, 32'h422A_CCCC);
        @(posedge clk);
        #1;
        chk("lat_b", sum, 32'h4000_0000);

        // Reset asserted mid-stream clears the output at once.
        run_vec("pre_rst", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.sum", sum, 32'd0);
        chk("mid_rst.ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post1", 32'hC175_C28F, 32'hC1C4_CCCC, 32'hC21F_D709, 1'b0);
        run_vec("post2", 32'h4304_3FBE, 32'h419F_5C28, 32'h4318_2B43, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
